// File: rtl/handshake_memory_pkg.sv
// Shared types for the handshaked data memory.
// Access widths, FSM states and the width-to-byte-count helper.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD,
        MEM_DOUBLE
    } mem_width_e;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_RESP
    } mem_state_e;

    function automatic int unsigned width_bytes(mem_width_e w);
        int unsigned n;
        unique case (w)
            MEM_BYTE: n = 1;
            MEM_HALF: n = 2;
            MEM_WORD: n = 4;
            default:  n = 8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/handshake_memory_if.sv
// Request/response handshake bundle between the LSU and the data memory.
// The LSU side is master, the memory is slave.
interface handshake_memory_if
    import mem_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    mem_width_e      req_width;
    logic            req_sign_extend;
    logic            req_write;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;

    modport master (
        output req_valid, req_addr, req_wdata,
        output req_width, req_sign_extend, req_write,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, req_wdata,
        input  req_width, req_sign_extend, req_write,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/handshake_memory_access_check.sv
// Combinational access legality check: width support, null address,
// array bounds (with carry past 2^XLEN) and optional alignment.
module mem_access_check
    import mem_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int MEM_SIZE         = 1024,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic [XLEN-1:0] addr,
    input  mem_width_e      width,
    output logic            fault
);
    logic [3:0]    nbytes;
    logic [XLEN:0] last;
    logic          too_wide;
    logic          misaligned;

    always_comb begin
        nbytes     = 4'(width_bytes(width));
        // One extra bit so an access wrapping the address space faults
        last       = {1'b0, addr} + (XLEN+1)'(nbytes) - (XLEN+1)'(1);
        too_wide   = (XLEN == 32) && (width == MEM_DOUBLE);
        misaligned = (addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
        fault      = too_wide
                   || (addr == '0)
                   || (last >= (XLEN+1)'(MEM_SIZE))
                   || ((ALLOW_MISALIGNED == 0) && misaligned);
    end

endmodule

// File: rtl/handshake_memory.sv
// Byte-addressed data memory behind valid/ready handshakes with a
// programmable access latency; one access outstanding at a time.
module handshake_memory
    import mem_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int MEM_SIZE         = 1024,
    parameter int LATENCY          = 2,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic              clock,
    input  logic              reset,
    handshake_memory_if.slave bus
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int NB = XLEN / 8;

    mem_state_e      state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;
    mem_width_e      width_q;
    logic            sext_q;
    logic            write_q;
    logic            fault_q;
    logic            ready_q;
    logic            valid_q;
    logic            fault_o;
    logic [XLEN-1:0] rdata_q;
    logic [7:0]      mem [MEM_SIZE];

    logic chk_fault;

    mem_access_check #(
        .XLEN             (XLEN),
        .MEM_SIZE         (MEM_SIZE),
        .ALLOW_MISALIGNED (ALLOW_MISALIGNED)
    ) u_check (
        .addr  (bus.req_addr),
        .width (bus.req_width),
        .fault (chk_fault)
    );

    logic            exec;
    logic [AW-1:0]   x_addr;
    logic [XLEN-1:0] x_wdata;
    mem_width_e      x_width;
    logic            x_sext;
    logic            x_write;
    logic            x_fault;

    // With LATENCY=1 the access executes on the accept edge itself
    always_comb begin
        if (LATENCY == 1) begin
            exec    = (state == MEM_IDLE) && bus.req_valid;
            x_addr  = bus.req_addr[AW-1:0];
            x_wdata = bus.req_wdata;
            x_width = bus.req_width;
            x_sext  = bus.req_sign_extend;
            x_write = bus.req_write;
            x_fault = chk_fault;
        end else begin
            exec    = (state == MEM_WAIT) && (cnt == '0);
            x_addr  = addr_q;
            x_wdata = wdata_q;
            x_width = width_q;
            x_sext  = sext_q;
            x_write = write_q;
            x_fault = fault_q;
        end
    end

    logic [3:0]      nbytes;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] load_data;
    logic            msb;

    always_comb begin
        nbytes = 4'(width_bytes(x_width));
        if (nbytes > 4'(NB)) nbytes = 4'(NB);
        raw = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes)) raw[8*i +: 8] = mem[x_addr + AW'(i)];
        end
        msb       = raw[8*int'(nbytes) - 1];
        load_data = raw;
        for (int b = 0; b < XLEN; b++) begin
            if (b >= 8*int'(nbytes)) load_data[b] = x_sext & msb;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= MEM_IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            fault_o <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            width_q <= MEM_BYTE;
            sext_q  <= 1'b0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            unique case (state)
                MEM_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr[AW-1:0];
                        wdata_q <= bus.req_wdata;
                        width_q <= bus.req_width;
                        sext_q  <= bus.req_sign_extend;
                        write_q <= bus.req_write;
                        fault_q <= chk_fault;
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state   <= MEM_RESP;
                            valid_q <= 1'b1;
                        end else begin
                            state <= MEM_WAIT;
                            cnt   <= CW'(LATENCY - 2);
                        end
                    end
                end
                MEM_WAIT: begin
                    if (cnt == '0) begin
                        state   <= MEM_RESP;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MEM_RESP: begin
                    if (bus.resp_ready) begin
                        state   <= MEM_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
            if (exec) begin
                fault_o <= x_fault;
                rdata_q <= (x_fault || x_write) ? '0 : load_data;
                if (x_write && !x_fault) begin
                    for (int i = 0; i < NB; i++) begin
                        if (i < int'(nbytes)) begin
                            mem[x_addr + AW'(i)] <= x_wdata[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_o;

endmodule

// File: tb/tb_handshake_memory.sv
// Self-checking bench: four memory configurations driven from one
// shared request bundle, compared against a byte-array reference model.
module tb_handshake_memory;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        r_valid  = 1'b0;
    logic        r_rready = 1'b0;
    logic        r_sext   = 1'b0;
    logic        r_write  = 1'b0;
    logic [1:0]  r_width  = 2'd0;
    logic [63:0] r_addr   = '0;
    logic [63:0] r_wdata  = '0;
    int          sel      = 0;

    int vectors     = 0;
    int miscompares = 0;

    handshake_memory_if #(.XLEN(32)) b0 ();
    handshake_memory_if #(.XLEN(32)) b1 ();
    handshake_memory_if #(.XLEN(32)) b2 ();
    handshake_memory_if #(.XLEN(64)) b3 ();

    assign b0.req_valid       = r_valid && sel == 0;
    assign b0.req_addr        = r_addr[31:0];
    assign b0.req_wdata       = r_wdata[31:0];
    assign b0.req_width       = mem_width_e'(r_width);
    assign b0.req_sign_extend = r_sext;
    assign b0.req_write       = r_write;
    assign b0.resp_ready      = r_rready && sel == 0;

    assign b1.req_valid       = r_valid && sel == 1;
    assign b1.req_addr        = r_addr[31:0];
    assign b1.req_wdata       = r_wdata[31:0];
    assign b1.req_width       = mem_width_e'(r_width);
    assign b1.req_sign_extend = r_sext;
    assign b1.req_write       = r_write;
    assign b1.resp_ready      = r_rready && sel == 1;

    assign b2.req_valid       = r_valid && sel == 2;
    assign b2.req_addr        = r_addr[31:0];
    assign b2.req_wdata       = r_wdata[31:0];
    assign b2.req_width       = mem_width_e'(r_width);
    assign b2.req_sign_extend = r_sext;
    assign b2.req_write       = r_write;
    assign b2.resp_ready      = r_rready && sel == 2;

    assign b3.req_valid       = r_valid && sel == 3;
    assign b3.req_addr        = r_addr;
    assign b3.req_wdata       = r_wdata;
    assign b3.req_width       = mem_width_e'(r_width);
    assign b3.req_sign_extend = r_sext;
    assign b3.req_write       = r_write;
    assign b3.resp_ready      = r_rready && sel == 3;

    handshake_memory #(.XLEN(32), .MEM_SIZE(1024), .LATENCY(2),
                       .ALLOW_MISALIGNED(1))
        d0 (.clock(clk), .reset(rst), .bus(b0));
    handshake_memory #(.XLEN(32), .MEM_SIZE(1024), .LATENCY(2),
                       .ALLOW_MISALIGNED(0))
        d1 (.clock(clk), .reset(rst), .bus(b1));
    handshake_memory #(.XLEN(32), .MEM_SIZE(1024), .LATENCY(3),
                       .ALLOW_MISALIGNED(1))
        d2 (.clock(clk), .reset(rst), .bus(b2));
    handshake_memory #(.XLEN(64), .MEM_SIZE(1024), .LATENCY(1),
                       .ALLOW_MISALIGNED(1))
        d3 (.clock(clk), .reset(rst), .bus(b3));

    logic        o_rv;
    logic        o_qr;
    logic        o_f;
    logic [63:0] o_rd;

    always_comb begin
        o_rv = b0.resp_valid;
        o_qr = b0.req_ready;
        o_f  = b0.resp_fault;
        o_rd = {32'h0, b0.resp_rdata};
        case (sel)
            1: begin
                o_rv = b1.resp_valid; o_qr = b1.req_ready;
                o_f  = b1.resp_fault; o_rd = {32'h0, b1.resp_rdata};
            end
            2: begin
                o_rv = b2.resp_valid; o_qr = b2.req_ready;
                o_f  = b2.resp_fault; o_rd = {32'h0, b2.resp_rdata};
            end
            3: begin
                o_rv = b3.resp_valid; o_qr = b3.req_ready;
                o_f  = b3.resp_fault; o_rd = b3.resp_rdata;
            end
            default: ;
        endcase
    end

    // Reference model: one byte array per instance
    logic [7:0] mm [4][1024];

    function automatic void model(input int d, input logic [63:0] a_in,
                                  input int w, input bit sx, input bit wr,
                                  input logic [63:0] wd,
                                  output bit f, output logic [63:0] rd);
        int          xl;
        int          n;
        bit          mis_ok;
        logic [63:0] a;
        logic [64:0] last;
        xl     = (d == 3) ? 64 : 32;
        mis_ok = (d != 1);
        n      = 1 << w;
        a      = (xl == 32) ? {32'h0, a_in[31:0]} : a_in;
        last   = {1'b0, a} + 65'(n) - 65'd1;
        f = (xl == 32 && w == 3) || a == 0 || last >= 65'd1024
            || (!mis_ok && (a % 64'(n)) != 0);
        rd = '0;
        if (f) return;
        for (int i = 0; i < n; i++) begin
            if (wr) mm[d][int'(a) + i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mm[d][int'(a) + i];
        end
        if (!wr && sx && 8*n < xl && rd[8*n-1])
            rd = rd | ~((64'd1 << (8*n)) - 64'd1);
        if (xl == 32) rd[63:32] = '0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xact(input int d, input logic [63:0] a, input int w,
                        input bit sx, input bit wr, input logic [63:0] wd,
                        input int stall,
                        output logic [63:0] got, output bit gf);
        bit          ef;
        logic [63:0] er;
        int          lat;
        int          n;
        model(d, a, w, sx, wr, wd, ef, er);
        lat      = (d == 2) ? 3 : (d == 3) ? 1 : 2;
        sel      = d;
        r_addr   = a;
        r_width  = w[1:0];
        r_sext   = sx;
        r_write  = wr;
        r_wdata  = wd;
        r_rready = 1'b0;
        r_valid  = 1'b1;
        #1;
        chk("req_ready idle", 64'(o_qr), 64'd1);
        @(posedge clk); #1;
        r_valid = 1'b0;
        n = 1;
        while (!o_rv && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        got = o_rd;
        gf  = o_f;
        chk("rdata", o_rd, er);
        chk("fault", 64'(o_f), 64'(ef));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold valid", 64'(o_rv), 64'd1);
            chk("hold rdata", o_rd, er);
            chk("hold fault", 64'(o_f), 64'(ef));
            chk("hold req_ready", 64'(o_qr), 64'd0);
        end
        r_rready = 1'b1;
        @(posedge clk); #1;
        r_rready = 1'b0;
        chk("resp_valid drop", 64'(o_rv), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] g;
        bit          f;
        logic [63:0] a;
        int          d;
        int          w;

        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 64'(o_qr), 64'd1);
        chk("reset resp_valid", 64'(o_rv), 64'd0);
        chk("reset rdata", o_rd, 64'd0);
        chk("reset fault", 64'(o_f), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        xact(0, 64'h100, 2, 0, 1, 64'hDEADBEEF, 0, g, f);
        chk("t1 store fault", 64'(f), 64'd0);
        xact(0, 64'h100, 0, 1, 0, 64'h0, 0, g, f);
        chk("t1 lb signed", g, 64'hFFFFFFEF);
        xact(0, 64'h102, 1, 0, 0, 64'h0, 0, g, f);
        chk("t1 lhu", g, 64'h0000DEAD);

        xact(0, 64'h0, 2, 0, 0, 64'h0, 0, g, f);
        chk("t2 null fault", 64'(f), 64'd1);
        xact(0, 64'h3FE, 2, 0, 0, 64'h0, 0, g, f);
        chk("t2 bound fault", 64'(f), 64'd1);
        xact(0, 64'h10, 3, 0, 0, 64'h0, 0, g, f);
        chk("t2 dw fault", 64'(f), 64'd1);
        chk("t2 dw rdata", g, 64'd0);
        xact(0, 64'h3FD, 0, 0, 1, 64'h5A, 0, g, f);
        xact(0, 64'h3FD, 2, 0, 1, 64'h11223344, 0, g, f);
        chk("t2 store fault", 64'(f), 64'd1);
        xact(0, 64'h3FD, 0, 0, 0, 64'h0, 0, g, f);
        chk("t2 byte intact", g, 64'h5A);

        xact(1, 64'h100, 2, 0, 1, 64'hCAFEF00D, 0, g, f);
        xact(1, 64'h101, 1, 0, 0, 64'h0, 0, g, f);
        chk("t3 misaligned fault", 64'(f), 64'd1);
        xact(0, 64'h101, 1, 0, 0, 64'h0, 0, g, f);
        chk("t3 misaligned ok", g, 64'hADBE);

        xact(0, 64'h100, 2, 0, 0, 64'h0, 5, g, f);
        chk("t4 stalled data", g, 64'hDEADBEEF);
        xact(0, 64'h103, 0, 0, 0, 64'h0, 0, g, f);
        chk("t4 back to back", g, 64'hDE);

        xact(2, 64'h200, 2, 0, 1, 64'hA5A5A5A5, 0, g, f);
        sel     = 2;
        r_addr  = 64'h200;
        r_width = 2'd2;
        r_write = 1'b1;
        r_wdata = 64'h12345678;
        r_valid = 1'b1;
        @(posedge clk); #1;
        r_valid = 1'b0;
        chk("t5 waiting", 64'(o_rv), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5 reset valid", 64'(o_rv), 64'd0);
        chk("t5 reset ready", 64'(o_qr), 64'd1);
        chk("t5 reset rdata", o_rd, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(2, 64'h200, 2, 0, 0, 64'h0, 0, g, f);
        chk("t5 store dropped", g, 64'hA5A5A5A5);

        xact(3, 64'h10, 2, 0, 1, 64'h80000000, 0, g, f);
        xact(3, 64'h10, 2, 1, 0, 64'h0, 0, g, f);
        chk("t6 lw signed", g, 64'hFFFFFFFF80000000);
        xact(3, 64'h8, 3, 0, 1, 64'h0123456789ABCDEF, 0, g, f);
        xact(3, 64'h8, 3, 0, 0, 64'h0, 0, g, f);
        chk("t6 ld", g, 64'h0123456789ABCDEF);
        xact(3, 64'hFFFFFFFFFFFFFFFC, 3, 0, 0, 64'h0, 0, g, f);
        chk("t6 wrap fault", 64'(f), 64'd1);

        for (int k = 0; k < 16; k++)
            xact(0, 64'h300 + 64'(4*k), 2, 0, 1, 64'($urandom), 0, g, f);
        for (int k = 0; k < 8; k++)
            xact(3, 64'h300 + 64'(8*k), 3, 0, 1,
                 {$urandom, $urandom}, 0, g, f);
        for (int it = 0; it < 80; it++) begin
            d = (it % 2 == 1) ? 3 : 0;
            w = int'($urandom_range(0, 3));
            a = 64'h300 + 64'($urandom_range(0, 56));
            if ($urandom_range(0, 7) == 0)
                a = {$urandom, $urandom} | 64'h10000;
            xact(d, a, w, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, {$urandom, $urandom},
                 int'($urandom_range(0, 2)), g, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
